// File: rtl/serial_alu_seq.sv
// ============================================================================
// Module  : serial_alu_seq
// Brief   : Bit-serial ALU (AND/OR/ADD/SLT) processing one bit per clock, LSB first.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       control,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             overflow
);

  localparam int IDXW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       ctl_q;
  logic [IDXW-1:0]  idx;
  logic             carry;
  logic [WIDTH-1:0] shreg;

  logic             ai;
  logic             bi;
  logic             sum;
  logic             carry_nxt;
  logic             res_bit;
  logic             ovf_raw;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] res_final;

  always_comb begin
    ai        = a_q[idx] ^ ctl_q[3];
    bi        = b_q[idx] ^ ctl_q[2];
    sum       = ai ^ bi ^ carry;
    carry_nxt = (ai & bi) | (ai & carry) | (bi & carry);
    case (ctl_q[1:0])
      2'b00:   res_bit = ai & bi;
      2'b01:   res_bit = ai | bi;
      default: res_bit = sum;
    endcase
    res_full = {res_bit, shreg[WIDTH-1:1]};
    // On the MSB slice, carry holds carry-in and carry_nxt the carry-out.
    ovf_raw  = carry ^ carry_nxt;
    if (ctl_q[1:0] == 2'b11) begin
      res_final = {{(WIDTH-1){1'b0}}, sum ^ ovf_raw};
    end else begin
      res_final = res_full;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      ctl_q    <= '0;
      idx      <= '0;
      carry    <= 1'b0;
      shreg    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      cout     <= 1'b0;
      zero     <= 1'b1;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            ctl_q <= control;
            idx   <= '0;
            carry <= control[2];
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          carry <= carry_nxt;
          shreg <= res_full;
          if (idx == LAST_IDX) begin
            // Visible outputs change only here, so they hold through the next RUN.
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            result   <= res_final;
            cout     <= carry_nxt;
            overflow <= ctl_q[1] & ovf_raw;
            zero     <= (res_final == '0);
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_alu_seq.md
SERIAL_ALU_SEQ -- requirements
Module: serial_alu_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request new operation; sampled on rising clk.
REQ-005 a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 control  input  4  [3]=A invert, [2]=B negate, [1:0]: 00 AND, 01 OR, 10 ADD, 11 SLT; captured with operands.
REQ-008 busy  output  1  high while bits are being processed.
REQ-009 done  output  1  one-cycle pulse: result/flags valid.
REQ-010 result  output  WIDTH  operation result.
REQ-011 cout  output  1  final carry out of the MSB slice.
REQ-012 zero  output  1  high when result == 0.
REQ-013 overflow  output  1  signed overflow for ADD/SLT; 0 for AND/OR.

Function
REQ-014 FSM states: IDLE, RUN, DONE; start accepted only in IDLE or DONE; start in RUN is ignored.
REQ-015 On acceptance: latch a, b, control; bit index = 0; carry flop = control[2]; next state RUN.
REQ-016 RUN processes one bit per cycle, LSB first: ai = a[i]^control[3], bi = b[i]^control[2], sum = ai^bi^carry, carry <= majority(ai,bi,carry).
REQ-017 Per-bit result: AND -> ai&bi, OR -> ai|bi, ADD -> sum, SLT -> sum (temporary); bit shifted into result register from the MSB end.
REQ-018 After bit WIDTH-1 is processed: next state DONE; index never exceeds WIDTH-1 (no wrap into a second pass).
REQ-019 Latency: start sampled at edge k -> done high for exactly the cycle following edge k+WIDTH; busy high from edge k+1 through edge k+WIDTH.
REQ-020 cout = carry out of bit WIDTH-1 for every op (carry chain always evaluated).
REQ-021 overflow = carry-into-MSB XOR carry-out-of-MSB when control[1]=1; 0 otherwise.
REQ-022 SLT: result = {WIDTH-1 zeros, sum_msb XOR overflow} (signed less-than); cout/overflow report the underlying subtraction.
REQ-023 zero evaluated on the final result (after the SLT substitution).
REQ-024 result, cout, zero, overflow hold their values from DONE until the next accepted start's DONE; they are not updated mid-RUN.
REQ-025 DONE lasts one cycle, then IDLE unless start is high, in which case it goes directly to RUN (back-to-back ops, no bubble).
REQ-026 control[3]=1, control[2]=1, op AND gives NOR; control[2]=1 with ADD gives a-b (two's complement).

Reset
REQ-027 rst high asynchronously forces state IDLE, busy=0, done=0, result=0, cout=0, overflow=0, zero=1, index=0, carry=0.
REQ-028 rst asserted mid-RUN aborts the operation; no done pulse; first start after rst release is accepted normally.

Verification (WIDTH=8)
REQ-029 ADD 0010, a=3C b=05 -> result 41, cout 0, overflow 0, zero 0; done exactly 8 edges after start sampled, busy high for 8 cycles.
REQ-030 SUB 0110: a=05 b=07 -> FE, cout 0; a=07 b=07 -> 00, zero 1, cout 1; ADD a=7F b=01 -> 80, overflow 1.
REQ-031 SLT 0111: a=80 b=01 -> 01; a=7F b=80 -> 00 with overflow 1; a=05 b=05 -> 00, zero 1.
REQ-032 Logic: AND a=F0 b=3C -> 30; OR -> FC; NOR 1100 a=00 b=0F -> F0; overflow 0 in all.
REQ-033 start pulsed during RUN with different operands -> ignored, original result reported; start held high through DONE -> next op begins without an idle cycle.
REQ-034 rst asserted after 3 bits of RUN -> outputs at reset values immediately (asynchronously, before the next clk edge), no done pulse; subsequent ADD 01+01 -> 02.
